// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and execute requesters, one transaction in flight.
// Define ARB_PERF_CNT_EN to build the grant/stall performance counters.
module mem_port_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DWIDTH-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [AWIDTH-1:0] m_addr,
    output logic [DWIDTH-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DWIDTH-1:0] m_rdata,
    output logic              busy,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_stall_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            sel;
    logic [3:0]        starve_q, starve_d;
    logic              store_q, store_d;
    logic              mReqC, mWeC, iGntC, dGntC, iRvalidC, dRvalidC;
    logic [1:0]        mSizeC;
    logic [AWIDTH-1:0] mAddrC;
    logic [DWIDTH-1:0] mWdataC, iRdataC, dRdataC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            store_q  <= store_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        store_d  = store_q;
        sel      = OWN_NONE;
        mReqC    = 1'b0;
        mWeC     = 1'b0;
        mSizeC   = 2'd0;
        mAddrC   = '0;
        mWdataC  = '0;
        iGntC    = 1'b0;
        dGntC    = 1'b0;
        iRvalidC = 1'b0;
        dRvalidC = 1'b0;
        iRdataC  = '0;
        dRdataC  = '0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // Data wins contention unless fetch has lost MAX_STARVE times in a row.
                    sel      = (d_req && !(i_req && starve_q == STARVE_LIMIT)) ? OWN_D : OWN_I;
                    owner_d  = sel;
                    store_d  = (sel == OWN_D) && d_we;
                    state_d  = m_gnt ? WAIT_RSP : WAIT_GNT;
                    if (sel == OWN_D && i_req)
                        starve_d = (starve_q == STARVE_LIMIT) ? starve_q : starve_q + 4'd1;
                    else
                        starve_d = '0;
                end
            end
            WAIT_GNT: begin
                sel = owner_q;
                if (m_gnt)
                    state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (m_rvalid) begin
                    if (owner_q == OWN_I) begin
                        iRvalidC = 1'b1;
                        iRdataC  = m_rdata;
                    end else if (owner_q == OWN_D) begin
                        dRvalidC = 1'b1;
                        dRdataC  = store_q ? '0 : m_rdata;
                    end
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
        if (sel == OWN_I) begin
            mReqC  = 1'b1;
            mSizeC = 2'd2;
            mAddrC = i_addr;
            iGntC  = m_gnt;
        end else if (sel == OWN_D) begin
            mReqC   = 1'b1;
            mWeC    = d_we;
            mSizeC  = d_size;
            mAddrC  = d_addr;
            mWdataC = d_wdata;
            dGntC   = m_gnt;
        end
    end

    // Arbitration is combinational from the requests, so outputs are held at 0 while reset is low.
    always_comb begin
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_size   = 2'd0;
        m_addr   = '0;
        m_wdata  = '0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (reset) begin
            m_req    = mReqC;
            m_we     = mWeC;
            m_size   = mSizeC;
            m_addr   = mAddrC;
            m_wdata  = mWdataC;
            i_gnt    = iGntC;
            d_gnt    = dGntC;
            i_rvalid = iRvalidC;
            d_rvalid = dRvalidC;
            i_rdata  = iRdataC;
            d_rdata  = dRdataC;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perfI_q, perfD_q, perfStall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfI_q     <= '0;
            perfD_q     <= '0;
            perfStall_q <= '0;
        end else begin
            perfI_q     <= perfI_q + {31'd0, iGntC};
            perfD_q     <= perfD_q + {31'd0, dGntC};
            perfStall_q <= perfStall_q + {31'd0, (i_req & ~iGntC) | (d_req & ~dGntC)};
        end
    end

    assign perf_i_cnt     = perfI_q;
    assign perf_d_cnt     = perfD_q;
    assign perf_stall_cnt = perfStall_q;
`else
    assign perf_i_cnt     = '0;
    assign perf_d_cnt     = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single `memory` instance between two requesters: the `fetch` instruction port and the `execute` load/store data port.
- Sits between those stages and `memory` in the pd top level.
- One transaction in flight at a time.
- Data has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
MAX_STARVE, 4, consecutive contended data grants before fetch is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch read request; held with i_addr until i_gnt
i_addr  in  AWIDTH  fetch address
i_gnt  out  1  fetch request accepted by memory this cycle
i_rvalid  out  1  fetch read data valid
i_rdata  out  DWIDTH  fetch read data
d_req  in  1  data request; held with d_we/d_size/d_addr/d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_size  in  2  0 = byte, 1 = half, 2 = word
d_addr  in  AWIDTH  data address
d_wdata  in  DWIDTH  store data
d_gnt  out  1  data request accepted
d_rvalid  out  1  load data valid / store acknowledge
d_rdata  out  DWIDTH  load data (0 on store ack)
m_req  out  1  request to memory
m_we  out  1  write enable to memory
m_size  out  2  access size to memory
m_addr  out  AWIDTH  address to memory
m_wdata  out  DWIDTH  write data to memory
m_gnt  in  1  memory accepts m_req this cycle
m_rvalid  in  1  memory response (reads and writes)
m_rdata  in  DWIDTH  memory read data
busy  out  1  FSM not in IDLE
perf_i_cnt  out  32  fetch grants (see Optional Feature)
perf_d_cnt  out  32  data grants
perf_stall_cnt  out  32  cycles with a requester waiting

Behaviour:
- **Reset.** Reset asserted (low) immediately forces:
  - FSM = IDLE, owner = NONE, starve_cnt = 0, perf counters = 0.
  - All outputs 0.
  - Any in-flight response is dropped.
- **m_rvalid outside WAIT_RSP.** Ignored, never routed.
- **FSM states:** IDLE, WAIT_GNT, WAIT_RSP.
- **IDLE, arbitration (combinational):**
  - Only one req high: that requester wins.
  - Both high: D wins, unless starve_cnt == MAX_STARVE, in which case I wins.
  - Winner's fields drive m_* with m_req = 1 in the same cycle.
  - m_gnt = 1 that cycle: winner's gnt = 1, owner latched, go to WAIT_RSP.
  - m_gnt = 0: owner latched, go to WAIT_GNT.
  - For I, m_we = 0 and m_size = 2.
- **WAIT_GNT:**
  - m_req = 1, driven from the owner's (held) inputs; the non-owner is not considered.
  - On m_gnt: owner gnt = 1 (combinational pass-through), go to WAIT_RSP.
- **WAIT_RSP:**
  - m_req = 0.
  - On m_rvalid: owner rvalid = 1 and owner rdata = m_rdata in the same cycle, then go to IDLE.
  - No new arbitration that cycle; minimum 2 cycles per transaction.
- **Response routing.** Non-owner rvalid/rdata stay 0 at all times. rdata is 0 whenever rvalid = 0.
- **Starvation counter** (4 bits, updated when a grant occurs in arbitration):
  - D granted while i_req = 1: increment, saturating at MAX_STARVE.
  - I granted, or D granted with i_req = 0: clear to 0.
- **Simultaneous events:**
  - A requester may drop req only after its gnt.
  - A new req from the owner during WAIT_RSP waits for IDLE.
- **Illegal d_size = 3:** passed through unchanged; the memory owns the error.
- busy = (state != IDLE).

Optional Feature:
ARB_PERF_CNT_EN
- Defined:
  - perf_i_cnt increments on each i_gnt.
  - perf_d_cnt increments on each d_gnt.
  - perf_stall_cnt increments each cycle with (i_req & ~i_gnt) | (d_req & ~d_gnt).
  - All counters are 32-bit, wrap at 2^32 - 1 → 0, and clear on reset.
- Undefined: perf_* outputs tied to 0 and no counter flops are inferred. Ports are present in both builds.

Test Plan:
- Reset released, i_req = 1, i_addr = 0x1000, memory grants immediately and responds 1 cycle later with 0x00000013 → m_addr = 0x1000 and i_gnt in cycle 0; i_rvalid = 1 with i_rdata = 0x00000013 in cycle 1; busy then 0.
- i_req and d_req both high, d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF, d_size = 2 → d_gnt first, m_we = 1, m_wdata = 0xDEADBEEF; after d_rvalid, next arbitration grants I.
- MAX_STARVE = 4, d_req and i_req held high continuously → grant order D, D, D, D, I, D…; starve_cnt returns to 0 after the I grant.
- Memory holds m_gnt = 0 for 3 cycles on a D load → m_req and m_addr stable for all 3 cycles; d_gnt only on the m_gnt cycle; i_req raised meanwhile is not granted.
- reset pulsed low while in WAIT_RSP, then m_rvalid = 1 arrives after release → no i_rvalid/d_rvalid; FSM in IDLE; all outputs 0 during reset.
- ARB_PERF_CNT_EN defined, 3 I grants and 2 D grants with 5 waiting cycles → perf_i_cnt = 3, perf_d_cnt = 2, perf_stall_cnt = 5. Undefined: all three read 0.
